// File: rtl/regfile_mp.sv
// Multi-port flop-based register file: synchronous reset, highest-port-wins
// write priority, optional zero register, optional write-to-read bypass.
module regfile_mp #(
  parameter int unsigned      WIDTH      = 32,
  parameter int unsigned      N_REG      = 32,
  parameter int unsigned      N_RPORTS   = 2,
  parameter int unsigned      N_WPORTS   = 1,
  parameter bit               ZERO_REG   = 1'b1,
  parameter bit               BYPASS     = 1'b1,
  parameter int unsigned      RD_LATENCY = 0,
  parameter logic [WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [N_RPORTS-1:0][$clog2(N_REG)-1:0] raddr,
  input  logic [N_RPORTS-1:0]                    ren,
  output logic [N_RPORTS-1:0][WIDTH-1:0]         rdata,
  input  logic [N_WPORTS-1:0][$clog2(N_REG)-1:0] waddr,
  input  logic [N_WPORTS-1:0]                    wen,
  input  logic [N_WPORTS-1:0][WIDTH-1:0]         wdata,
  output logic                                   wconflict
);

  localparam int unsigned AW = $clog2(N_REG);

  logic [WIDTH-1:0]                  mem [N_REG];
  logic [N_REG-1:0]                  wr_hit;
  logic [N_REG-1:0][WIDTH-1:0]       wr_val;
  logic                              conflict_c;
  logic [N_RPORTS-1:0][WIDTH-1:0]    rval;

  // Per-register write decode; later ports overwrite earlier ones so the
  // highest-index port wins. A second hit on the same register is a conflict.
  always_comb begin
    wr_hit     = '0;
    wr_val     = '0;
    conflict_c = 1'b0;
    for (int unsigned r = 0; r < N_REG; r++) begin
      for (int unsigned p = 0; p < N_WPORTS; p++) begin
        if (rst_n && wen[p] && (waddr[p] == AW'(r)) && !(ZERO_REG && (r == 0))) begin
          if (wr_hit[r]) conflict_c = 1'b1;
          wr_hit[r] = 1'b1;
          wr_val[r] = wdata[p];
        end
      end
    end
  end

  // Storage and conflict flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < N_REG; r++) mem[r] <= RESET_VAL;
      wconflict <= 1'b0;
    end else begin
      for (int unsigned r = 0; r < N_REG; r++) begin
        if (wr_hit[r]) mem[r] <= wr_val[r];
      end
      wconflict <= conflict_c;
    end
  end

  // Read value; out-of-range addresses and the zero register fall through to 0
  always_comb begin
    rval = '0;
    for (int unsigned j = 0; j < N_RPORTS; j++) begin
      for (int unsigned r = 0; r < N_REG; r++) begin
        if ((raddr[j] == AW'(r)) && !(ZERO_REG && (r == 0))) begin
          rval[j] = (BYPASS && wr_hit[r]) ? wr_val[r] : mem[r];
        end
      end
    end
  end

  if (RD_LATENCY == 0) begin : g_rd_comb
    logic unused_ren;
    assign unused_ren = ^ren;
    assign rdata      = rval;
  end else begin : g_rd_reg
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        rdata <= '0;
      end else begin
        for (int unsigned j = 0; j < N_RPORTS; j++) begin
          if (ren[j]) rdata[j] <= rval[j];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: three configurations share one stimulus bus
// (comb+bypass, registered without bypass on 24 regs, registered+bypass).
module tb_regfile_mp;

  localparam logic [31:0] RV = 32'hA5A5_0000;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [1:0][4:0]       raddr;
  logic [1:0]            ren;
  logic [2:0][4:0]       waddr;
  logic [2:0]            wen;
  logic [2:0][31:0]      wdata;
  logic [1:0][31:0]      rdata0, rdata1, rdata2;
  logic                  wc0, wc1, wc2;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  regfile_mp #(.WIDTH(32), .N_REG(32), .N_RPORTS(2), .N_WPORTS(3), .ZERO_REG(1'b1),
               .BYPASS(1'b1), .RD_LATENCY(0), .RESET_VAL(RV)) u0 (
    .clk(clk), .rst_n(rst_n), .raddr(raddr), .ren(ren), .rdata(rdata0),
    .waddr(waddr), .wen(wen), .wdata(wdata), .wconflict(wc0));

  regfile_mp #(.WIDTH(32), .N_REG(24), .N_RPORTS(2), .N_WPORTS(3), .ZERO_REG(1'b1),
               .BYPASS(1'b0), .RD_LATENCY(1), .RESET_VAL(RV)) u1 (
    .clk(clk), .rst_n(rst_n), .raddr(raddr), .ren(ren), .rdata(rdata1),
    .waddr(waddr), .wen(wen), .wdata(wdata), .wconflict(wc1));

  regfile_mp #(.WIDTH(32), .N_REG(32), .N_RPORTS(2), .N_WPORTS(3), .ZERO_REG(1'b1),
               .BYPASS(1'b1), .RD_LATENCY(1), .RESET_VAL(RV)) u2 (
    .clk(clk), .rst_n(rst_n), .raddr(raddr), .ren(ren), .rdata(rdata2),
    .waddr(waddr), .wen(wen), .wdata(wdata), .wconflict(wc2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wen = '0;
    ren = '0;
  endtask

  task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d);
    wen[p]   = 1'b1;
    waddr[p] = a;
    wdata[p] = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle(); waddr = '0; wdata = '0;
    raddr[0] = 5'd0; raddr[1] = 5'd1; ren = 2'b11;
    tick();
    n_chk++; if (rdata0[0] !== 32'h0) begin n_fail++; $display("FAIL reset_zero_reg: got %h exp %h", rdata0[0], 32'h0); end
    n_chk++; if (rdata0[1] !== RV) begin n_fail++; $display("FAIL reset_reg1: got %h exp %h", rdata0[1], RV); end
    n_chk++; if (rdata1 !== 64'h0) begin n_fail++; $display("FAIL reset_rdata_reg_u1: got %h exp 0", rdata1); end
    n_chk++; if (rdata2 !== 64'h0) begin n_fail++; $display("FAIL reset_rdata_reg_u2: got %h exp 0", rdata2); end
    n_chk++; if ({wc0, wc1, wc2} !== 3'b000) begin n_fail++; $display("FAIL reset_wconflict: got %b exp 000", {wc0, wc1, wc2}); end
    raddr[0] = 5'd31; #1;
    n_chk++; if (rdata0[0] !== RV) begin n_fail++; $display("FAIL reset_reg31: got %h exp %h", rdata0[0], RV); end
    rst_n = 1'b1;
    tick();
    n_chk++; if (rdata1[0] !== 32'h0) begin n_fail++; $display("FAIL invalid_read_31: got %h exp 0", rdata1[0]); end
    n_chk++; if (rdata1[1] !== RV) begin n_fail++; $display("FAIL post_reset_reg1: got %h exp %h", rdata1[1], RV); end
    n_chk++; if (rdata2[0] !== RV) begin n_fail++; $display("FAIL post_reset_reg31: got %h exp %h", rdata2[0], RV); end
  endtask

  task automatic test_basic();
    idle(); wr(0, 5'd5, 32'hDEAD_BEEF);
    tick();
    idle(); raddr[0] = 5'd5; raddr[1] = 5'd5; ren = 2'b11; #1;
    n_chk++; if (rdata0 !== {2{32'hDEAD_BEEF}}) begin n_fail++; $display("FAIL basic_comb: got %h exp %h", rdata0, {2{32'hDEAD_BEEF}}); end
    tick();
    n_chk++; if (rdata1 !== {2{32'hDEAD_BEEF}}) begin n_fail++; $display("FAIL basic_reg: got %h exp %h", rdata1, {2{32'hDEAD_BEEF}}); end
  endtask

  task automatic test_bypass();
    idle(); wr(0, 5'd7, 32'h1234); raddr[0] = 5'd7; raddr[1] = 5'd7; ren = 2'b11; #1;
    n_chk++; if (rdata0[0] !== 32'h1234) begin n_fail++; $display("FAIL bypass_comb: got %h exp %h", rdata0[0], 32'h1234); end
    tick();
    n_chk++; if (rdata2[0] !== 32'h1234) begin n_fail++; $display("FAIL bypass_reg: got %h exp %h", rdata2[0], 32'h1234); end
    n_chk++; if (rdata1[0] !== RV) begin n_fail++; $display("FAIL nobypass_old: got %h exp %h", rdata1[0], RV); end
    wen = '0;
    tick();
    n_chk++; if (rdata1[0] !== 32'h1234) begin n_fail++; $display("FAIL nobypass_new: got %h exp %h", rdata1[0], 32'h1234); end
  endtask

  task automatic test_priority();
    idle(); wr(0, 5'd9, 32'd1); wr(1, 5'd9, 32'd2); wr(2, 5'd9, 32'd3);
    tick();
    idle(); raddr[0] = 5'd9; #1;
    n_chk++; if ({wc0, wc1} !== 2'b11) begin n_fail++; $display("FAIL conflict_set: got %b exp 11", {wc0, wc1}); end
    n_chk++; if (rdata0[0] !== 32'd3) begin n_fail++; $display("FAIL priority_win: got %h exp %h", rdata0[0], 32'd3); end
    wr(0, 5'd4, 32'h44); wr(1, 5'd6, 32'h66);
    tick();
    idle(); raddr[0] = 5'd4; raddr[1] = 5'd6; #1;
    n_chk++; if (wc0 !== 1'b0) begin n_fail++; $display("FAIL conflict_distinct: got %b exp 0", wc0); end
    n_chk++; if (rdata0 !== {32'h66, 32'h44}) begin n_fail++; $display("FAIL distinct_commit: got %h exp %h", rdata0, {32'h66, 32'h44}); end
    wr(0, 5'd0, 32'hAA); wr(1, 5'd0, 32'hBB);
    tick();
    idle(); raddr[0] = 5'd0; #1;
    n_chk++; if (wc0 !== 1'b0) begin n_fail++; $display("FAIL conflict_zero_reg: got %b exp 0", wc0); end
    n_chk++; if (rdata0[0] !== 32'h0) begin n_fail++; $display("FAIL zero_reg_write: got %h exp 0", rdata0[0]); end
  endtask

  task automatic test_zero_invalid();
    idle(); wr(0, 5'd0, 32'hFFFF); wr(1, 5'd30, 32'hFFFF);
    tick();
    idle(); raddr[0] = 5'd0; raddr[1] = 5'd30; ren = 2'b11;
    n_chk++; if (wc1 !== 1'b0) begin n_fail++; $display("FAIL invalid_conflict: got %b exp 0", wc1); end
    tick();
    n_chk++; if (rdata1 !== 64'h0) begin n_fail++; $display("FAIL zero_invalid_read: got %h exp 0", rdata1); end
    raddr[0] = 5'd5; raddr[1] = 5'd9;
    tick();
    n_chk++; if (rdata1 !== {32'd3, 32'hDEAD_BEEF}) begin n_fail++; $display("FAIL others_unchanged: got %h exp %h", rdata1, {32'd3, 32'hDEAD_BEEF}); end
  endtask

  task automatic test_reset_mid();
    idle(); wr(0, 5'd3, 32'h55);
    tick();
    rst_n = 1'b0; wr(0, 5'd3, 32'h77); raddr[0] = 5'd3; raddr[1] = 5'd5; ren = 2'b11;
    tick();
    n_chk++; if (rdata1[0] !== 32'h0) begin n_fail++; $display("FAIL mid_reset_rdata_u1: got %h exp 0", rdata1[0]); end
    n_chk++; if (rdata2[0] !== 32'h0) begin n_fail++; $display("FAIL mid_reset_rdata_u2: got %h exp 0", rdata2[0]); end
    n_chk++; if (rdata0[0] !== RV) begin n_fail++; $display("FAIL mid_reset_comb_reg3: got %h exp %h", rdata0[0], RV); end
    rst_n = 1'b1; idle(); ren = 2'b11;
    tick();
    n_chk++; if (rdata1 !== {RV, RV}) begin n_fail++; $display("FAIL after_reset_u1: got %h exp %h", rdata1, {RV, RV}); end
    n_chk++; if (rdata2[0] !== RV) begin n_fail++; $display("FAIL after_reset_u2: got %h exp %h", rdata2[0], RV); end
  endtask

  task automatic test_ren_hold();
    idle(); wr(2, 5'd3, 32'h99); raddr[0] = 5'd3;
    tick();
    idle();
    tick();
    n_chk++; if (rdata1[0] !== RV) begin n_fail++; $display("FAIL ren_hold_u1: got %h exp %h", rdata1[0], RV); end
    n_chk++; if (rdata2[0] !== RV) begin n_fail++; $display("FAIL ren_hold_u2: got %h exp %h", rdata2[0], RV); end
    n_chk++; if (rdata0[0] !== 32'h99) begin n_fail++; $display("FAIL comb_after_write: got %h exp %h", rdata0[0], 32'h99); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bypass();
    test_priority();
    test_zero_invalid();
    test_reset_mid();
    test_ren_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
